acm_bridge_multi: RTL

- Parametrised Wishbone B3 slave bridging the monitor bus to one or more Fusion Analog Configuration MUX (ACM) ports.
- Supersedes the fixed 8-bit, single-port, fixed-rate ACM controller.
- Adds:
  - generated ACM clock with a programmable divider;
  - NUM_PORTS ACM ports selected by address;
  - optional write-verify readback with bounded retry;
  - a CSR window reporting verify errors.

---
 rtl/acm_bridge_pkg.sv | 28 ++
 rtl/acm_clk_gen.sv | 51 +++++
 rtl/acm_bridge_multi.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/acm_bridge_pkg.sv
// Shared definitions for the Wishbone-to-ACM bridge: FSM encoding, CSR map
// and address window identifiers.
package acm_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_HOLD     = 3'd2,
    ST_CAPTURE  = 3'd3,
    ST_VSETUP   = 3'd4,
    ST_VCAPTURE = 3'd5,
    ST_ACK      = 3'd6
  } state_t;

  localparam int CSR_STATUS = 0;
  localparam int CSR_ERRCNT = 1;
  localparam int CSR_CLEAR  = 2;

  localparam int WIN_ACM = 0;
  localparam int WIN_CSR = 1;

  localparam int RETRY_W = 3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/acm_clk_gen.sv
// ACM clock generator: programmable half-period divider, rise/fall tick
// strobes (valid in the cycle before the acm_clk edge) and reset synchroniser.
module acm_clk_gen #(
  parameter int HALF_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_acm_clk,
  output logic o_acm_reset,
  output logic o_rise_tick,
  output logic o_fall_tick
);

  localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_sync;
  logic             r_acm_clk;
  logic             w_wrap;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[0], 1'b1};
    end
  end

  assign w_wrap = r_sync[1] && (r_div == DIV_W'(HALF_DIV - 1));

  // Divider only runs once the ACM side is out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div     <= '0;
      r_acm_clk <= 1'b0;
    end else if (r_sync[1]) begin
      if (w_wrap) begin
        r_div     <= '0;
        r_acm_clk <= ~r_acm_clk;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign o_acm_clk   = r_acm_clk;
  assign o_acm_reset = r_sync[1];
  assign o_rise_tick = w_wrap & ~r_acm_clk;
  assign o_fall_tick = w_wrap & r_acm_clk;

endmodule

// File: rtl/acm_bridge_multi.sv
// Wishbone B3 slave bridging to NUM_PORTS ACM ports with optional
// write-verify/retry and a CSR window reporting verify failures.
module acm_bridge_multi
  import acm_bridge_pkg::*;
#(
  parameter int WB_AW     = 16,
  parameter int WB_DW     = 16,
  parameter int ACM_AW    = 8,
  parameter int ACM_DW    = 8,
  parameter int NUM_PORTS = 1,
  parameter int HALF_DIV  = 2,
  parameter int VERIFY_EN = 1,
  parameter int NUM_RETRY = 2
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_n_i,
  input  logic                        wb_cyc_i,
  input  logic                        wb_stb_i,
  input  logic                        wb_we_i,
  input  logic [WB_AW-1:0]            wb_adr_i,
  input  logic [WB_DW-1:0]            wb_dat_i,
  output logic [WB_DW-1:0]            wb_dat_o,
  output logic                        wb_ack_o,
  output logic                        acm_clk,
  output logic                        acm_reset,
  output logic [ACM_AW-1:0]           acm_addr,
  output logic [ACM_DW-1:0]           acm_wdata,
  output logic [NUM_PORTS-1:0]        acm_wen,
  input  logic [NUM_PORTS*ACM_DW-1:0] acm_rdata
);

  localparam int HW    = WB_AW - ACM_AW - 2;
  localparam int OFF_W = ACM_AW + 2;

  state_t r_state, w_state_next;

  logic                 w_rise, w_fall;
  logic                 w_req, w_acm_hit, w_csr_hit;
  logic                 w_accept, w_drive, w_release, w_cap, w_vcheck;
  logic                 w_match, w_can_retry;
  logic [1:0]           w_p;
  logic [HW-1:0]        w_h;
  logic [OFF_W-1:0]     w_csr_off;
  logic [WB_DW-1:0]     w_csr_rd, w_rd_ext;
  logic [ACM_DW-1:0]    w_rd_sel;
  logic [NUM_PORTS-1:0] w_port_oh;
  logic [ACM_DW-1:0]    w_rd_port [NUM_PORTS];
  logic                 w_unused;

  logic [ACM_AW-1:0]    r_adr;
  logic [1:0]           r_port;
  logic                 r_we;
  logic [ACM_DW-1:0]    r_wdata;
  logic [RETRY_W-1:0]   r_retry;
  logic [ACM_DW-1:0]    r_rd_cap;
  logic [WB_DW-1:0]     r_dat;
  logic [ACM_AW-1:0]    r_acm_addr;
  logic [ACM_DW-1:0]    r_acm_wdata;
  logic [NUM_PORTS-1:0] r_acm_wen;
  logic                 r_fail, r_sticky;
  logic [RETRY_W-1:0]   r_last_retry;
  logic [15:0]          r_errcnt;

  acm_clk_gen #(
    .HALF_DIV(HALF_DIV)
  ) u_clk_gen (
    .i_clk      (wb_clk_i),
    .i_rst_n    (wb_rst_n_i),
    .o_acm_clk  (acm_clk),
    .o_acm_reset(acm_reset),
    .o_rise_tick(w_rise),
    .o_fall_tick(w_fall)
  );

  assign w_unused = &{1'b0, wb_dat_i};

  assign w_req     = wb_cyc_i & wb_stb_i;
  assign w_p       = wb_adr_i[ACM_AW+1:ACM_AW];
  assign w_h       = wb_adr_i[WB_AW-1:ACM_AW+2];
  assign w_acm_hit = (w_h == HW'(WIN_ACM)) && (int'(w_p) < NUM_PORTS);
  assign w_csr_hit = (w_h == HW'(WIN_CSR));
  assign w_csr_off = wb_adr_i[OFF_W-1:0];

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign w_rd_port[gi] = acm_rdata[gi*ACM_DW +: ACM_DW];
    assign w_port_oh[gi] = (r_port == 2'(gi));
  end

  always_comb begin
    w_rd_sel = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (r_port == 2'(p)) w_rd_sel = w_rd_port[p];
    end
  end

  always_comb begin
    w_rd_ext = '0;
    w_rd_ext[ACM_DW-1:0] = r_rd_cap;
  end

  always_comb begin
    w_csr_rd = '0;
    if (w_csr_off == OFF_W'(CSR_STATUS)) begin
      w_csr_rd[4:0] = {r_last_retry, r_sticky, r_fail};
    end else if (w_csr_off == OFF_W'(CSR_ERRCNT)) begin
      w_csr_rd[15:0] = r_errcnt;
    end
  end

  assign w_match     = (r_rd_cap == r_wdata);
  assign w_can_retry = (r_retry < RETRY_W'(NUM_RETRY));

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) r_state <= ST_IDLE;
    else             r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_req) w_state_next = w_acm_hit ? ST_SETUP : ST_ACK;
      ST_SETUP:    if (w_fall) w_state_next = ST_HOLD;
      ST_HOLD: begin
        if (w_fall) begin
          if (!r_we)               w_state_next = ST_CAPTURE;
          else if (VERIFY_EN != 0) w_state_next = ST_VSETUP;
          else                     w_state_next = ST_ACK;
        end
      end
      ST_CAPTURE:  if (w_fall) w_state_next = ST_ACK;
      ST_VSETUP:   if (w_fall) w_state_next = ST_VCAPTURE;
      ST_VCAPTURE: begin
        if (w_fall) w_state_next = (w_match || !w_can_retry) ? ST_ACK : ST_SETUP;
      end
      ST_ACK:      w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    wb_ack_o  = (r_state == ST_ACK);
    w_accept  = (r_state == ST_IDLE) && w_req;
    w_drive   = (r_state == ST_SETUP) && w_fall;
    w_release = (r_state == ST_HOLD) && w_fall;
    w_cap     = (r_state == ST_CAPTURE) && w_fall;
    w_vcheck  = (r_state == ST_VCAPTURE) && w_fall;
  end

  // Transfer datapath; ACM-facing outputs only ever move on fall ticks.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_adr       <= '0;
      r_port      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_retry     <= '0;
      r_rd_cap    <= '0;
      r_acm_addr  <= '0;
      r_acm_wdata <= '0;
      r_acm_wen   <= '0;
    end else begin
      if (w_accept) begin
        r_adr   <= wb_adr_i[ACM_AW-1:0];
        r_port  <= w_p;
        r_we    <= wb_we_i;
        r_wdata <= wb_dat_i[ACM_DW-1:0];
        r_retry <= '0;
      end
      if (w_drive) begin
        r_acm_addr  <= r_adr;
        r_acm_wdata <= r_wdata;
        r_acm_wen   <= r_we ? w_port_oh : '0;
      end
      if (w_release) r_acm_wen <= '0;
      // Sample mid-period so the ACM's registered data has settled.
      if (w_rise) r_rd_cap <= w_rd_sel;
      if (w_vcheck && !w_match && w_can_retry) r_retry <= r_retry + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_dat        <= '0;
      r_fail       <= 1'b0;
      r_sticky     <= 1'b0;
      r_last_retry <= '0;
      r_errcnt     <= '0;
    end else begin
      if (w_accept && !w_acm_hit) begin
        if (!wb_we_i) begin
          r_dat <= w_csr_hit ? w_csr_rd : '0;
        end else if (w_csr_hit && (w_csr_off == OFF_W'(CSR_CLEAR))) begin
          r_fail       <= 1'b0;
          r_sticky     <= 1'b0;
          r_last_retry <= '0;
          r_errcnt     <= '0;
        end
      end
      if (w_cap) r_dat <= w_rd_ext;
      if (w_release && r_we && (VERIFY_EN == 0)) begin
        r_fail       <= 1'b0;
        r_last_retry <= '0;
      end
      if (w_vcheck) begin
        if (w_match) begin
          r_fail       <= 1'b0;
          r_last_retry <= r_retry;
        end else if (!w_can_retry) begin
          r_fail       <= 1'b1;
          r_sticky     <= 1'b1;
          r_last_retry <= r_retry;
          r_errcnt     <= sat_inc16(r_errcnt);
        end
      end
    end
  end

  assign wb_dat_o  = r_dat;
  assign acm_addr  = r_acm_addr;
  assign acm_wdata = r_acm_wdata;
  assign acm_wen   = r_acm_wen;

endmodule
